prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, byte capacity of the queue; power of two, at least 8.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, fetch and head address after reset.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, synchronous and active-high.
REQ-005 Port flush, input, 1, redirects the instruction stream (jump or call) to flush_addr.
REQ-006 Port flush_addr, input, 32, new head address, sampled when flush=1.
REQ-007 Port mem_req, output, 1, byte read request to instruction memory.
REQ-008 Port mem_addr, output, 32, byte address of the request.
REQ-009 Port mem_rdata, input, 8, read byte, valid exactly one cycle after the cycle with mem_req=1.
REQ-010 Port consume, input, 1, decode retires consume_len bytes from the head.
REQ-011 Port consume_len, input, 3, number of bytes to retire, 1..4, driven from num_of_ope.
REQ-012 Port ope, output, 32, head instruction window; the head byte is in ope[31:24], and following bytes are in descending lanes.
REQ-013 Port ope_valid, output, 1, set when the byte count is at least 4.
REQ-014 Port ope_eip, output, 32, address of the head byte.
REQ-015 Port count, output, 4, number of bytes held.
REQ-016 Port consume_err, output, 1, sticky flag for an illegal consume.

Function
REQ-017 Storage is a circular byte buffer with rd_ptr and wr_ptr of log2(DEPTH) bits; both pointers wrap modulo DEPTH.
REQ-018 mem_req=1 in a cycle iff flush=0 and count + inflight + 1 <= DEPTH, where inflight = mem_req of the previous cycle; this allows back-to-back requests.
REQ-019 mem_addr is the internal fetch_addr, which increments by 1 (mod 2^32) on each cycle with mem_req=1.
REQ-020 In the cycle after a request, when not dropped, mem_rdata is written at wr_ptr, and wr_ptr and count each increment by 1.
REQ-021 ope lanes beyond count read as 8'h00; ope is combinational from buffer, rd_ptr and count.
REQ-022 A consume is accepted iff consume=1, flush=0, consume_len is in 1..4, and consume_len <= count.
REQ-023 On an accepted consume, rd_ptr advances by consume_len, and ope_eip advances by consume_len (mod 2^32).
REQ-024 With a simultaneous write and accepted consume, next count = count + 1 - consume_len; the retired bytes are taken from the pre-edge state.
REQ-025 On a rejected consume (consume=1 but the REQ-022 conditions fail, flush=0), state is unchanged and consume_err is set to 1.
REQ-026 Flush has priority over consume and fill.
REQ-027 On flush, count, rd_ptr and wr_ptr are cleared to 0, and fetch_addr and ope_eip take flush_addr.
REQ-028 On flush, consume_err is cleared, and the byte returning from a request issued in the flush cycle or the cycle before it is discarded via a drop flag.
REQ-029 Fetch resumes at flush_addr in the cycle after the flush, so the first new byte is stored 2 cycles after flush.
REQ-030 Full boundary: count never exceeds DEPTH; at count=DEPTH, mem_req=0.
REQ-031 Empty boundary: at count=0, ope=0 and ope_valid=0.
REQ-032 Refill latency from empty to ope_valid=1 is 5 cycles after the first mem_req.

Reset
REQ-033 When reset=1 at a clock edge, count, rd_ptr, wr_ptr, consume_err and the drop flag become 0, and fetch_addr and ope_eip become RESET_ADDR.
REQ-034 During and after reset, mem_req=0 in the reset cycle, ope=0, ope_valid=0, and any in-flight byte is discarded.
REQ-035 reset has priority over flush and consume; fetch restarts in the first cycle after reset deasserts.

Verification
REQ-036 Fill test: memory bytes 8b,5d,fc,89,45,... from address 0, reset, no consume -> ope=32'h8b5dfc89 and ope_valid=1 after 5 cycles; count saturates at 8; mem_req=0 while full.
REQ-037 Variable consume test: consume_len=2, then 3, then 1 -> ope_eip steps 0, 2, 5, 6; ope shows the correct byte windows; 16 wrapped bytes are consumed error-free.
REQ-038 Simultaneous test: consume_len=1 together with a byte write at count=7 -> count remains 7; then consume_len=4 with a write -> count=4.
REQ-039 Flush test: flush with flush_addr=32'h0000_0100 while a request is in flight -> count=0 and ope_eip=32'h100; the stale byte is not stored; the first stored byte comes from address 100.
REQ-040 Illegal consume test: consume_len=4 with count=2 -> no state change and consume_err=1; consume_err=1 holds until a flush clears it.
REQ-041 Reset mid-operation test: reset asserted at count=5 with mem_req=1 -> next cycle count=0, ope_eip=RESET_ADDR, mem_req=0; fetch resumes from RESET_ADDR.

Source files
------------

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-wide instruction prefetch queue with flush and variable-length consume
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   flush, flush_addr     redirect the stream to flush_addr, discarding every held byte
//   mem_req, mem_addr     one-byte read request to instruction memory
//   mem_rdata             read byte, returned the cycle after mem_req
//   consume, consume_len  retire 1..4 bytes from the head
//   ope, ope_valid        4-byte head window (head byte in ope[31:24]) and window-full flag
//   ope_eip               address of the head byte
//   count                 number of bytes held
//   consume_err           sticky illegal-consume flag, cleared by flush or reset
module prefetch_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        consume,
  input  logic [2:0]  consume_len,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] ope_eip,
  output logic [3:0]  count,
  output logic        consume_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   eip_q, eip_d;
  logic          inflight_q, inflight_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;

  logic          room_ok;
  logic          wr_en;
  logic          len_ok;
  logic          accept;
  logic          reject;
  logic [CW-1:0] len_c;

  // Reserve a slot for the byte still in flight so the buffer can never overflow,
  // while still allowing a request every cycle.
  assign room_ok = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
  assign mem_req = ~reset & ~flush & room_ok;
  assign mem_addr = fetch_addr_q;

  // A returning byte is stored unless a flush has invalidated its request.
  assign wr_en = inflight_q & ~drop_q;

  assign len_c  = CW'(consume_len);
  assign len_ok = (consume_len != 3'd0) && (consume_len <= 3'd4) && (len_c <= count_q);
  assign accept = consume & ~flush & len_ok;
  assign reject = consume & ~flush & ~len_ok;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    eip_d        = eip_q;
    err_d        = err_q;
    inflight_d   = mem_req;
    drop_d       = 1'b0;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      fetch_addr_d = flush_addr;
      eip_d        = flush_addr;
      err_d        = 1'b0;
      drop_d       = 1'b1;
    end else begin
      if (mem_req) begin
        fetch_addr_d = fetch_addr_q + 32'd1;
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (accept) begin
        rd_ptr_d = rd_ptr_q + AW'(consume_len);
        eip_d    = eip_q + 32'(consume_len);
      end
      if (reject) begin
        err_d = 1'b1;
      end
      // The consume length is checked against the pre-edge count; the byte
      // arriving this cycle lands after the retired ones are gone.
      count_d = count_q + CW'(wr_en) - (accept ? len_c : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_ADDR;
      eip_q        <= RESET_ADDR;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      eip_q        <= eip_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset: lanes beyond count are masked off in the window.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_en) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

  always_comb begin
    ope = '0;
    for (int i = 0; i < 4; i++) begin
      if (CW'(i) < count_q) begin
        ope[31-8*i -: 8] = fifo_q[rd_ptr_q + AW'(i)];
      end
    end
  end

  assign ope_valid   = count_q >= CW'(4);
  assign ope_eip     = eip_q;
  assign count       = 4'(count_q);
  assign consume_err = err_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue
module tb_prefetch_queue;

  localparam int          DEPTH      = 8;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        consume;
  logic [2:0]  consume_len;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] ope_eip;
  logic [3:0]  count;
  logic        consume_err;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .consume(consume), .consume_len(consume_len),
    .ope(ope), .ope_valid(ope_valid), .ope_eip(ope_eip),
    .count(count), .consume_err(consume_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: held bytes as a plain queue, head at index 0.
  logic [7:0]  m_q[$];
  logic [31:0] m_eip, m_fetch, m_inf_addr;
  logic        m_inf, m_err;
  logic        checking = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          lat;

  function automatic logic [7:0] mem_at(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h8b;
      32'd1:   return 8'h5d;
      32'd2:   return 8'hfc;
      32'd3:   return 8'h89;
      32'd4:   return 8'h45;
      default: return a[7:0] ^ 8'ha5 ^ {a[10:8], 5'b0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic exp_req(input logic r, input logic f);
    return !r && !f && ((m_q.size() + int'(m_inf)) < DEPTH);
  endfunction

  task automatic check_outputs(input logic r, input logic f);
    logic [31:0] w;
    logic        rq;
    w  = '0;
    rq = exp_req(r, f);
    for (int i = 0; i < 4; i++) begin
      if (i < m_q.size()) w[31-8*i -: 8] = m_q[i];
    end
    chk("mem_req", 32'(mem_req), 32'(rq));
    if (rq) chk("mem_addr", mem_addr, m_fetch);
    chk("ope", ope, w);
    chk("ope_valid", 32'(ope_valid), 32'(m_q.size() >= 4));
    chk("ope_eip", ope_eip, m_eip);
    chk("count", 32'(count), 32'(m_q.size()));
    chk("consume_err", 32'(consume_err), 32'(m_err));
  endtask

  task automatic model_step(input logic r, input logic f, input logic [31:0] fa,
                            input logic c, input logic [2:0] cl);
    logic rq;
    rq = exp_req(r, f);
    if (r) begin
      m_q.delete();
      m_eip = RESET_ADDR; m_fetch = RESET_ADDR; m_err = 1'b0; m_inf = 1'b0;
    end else if (f) begin
      m_q.delete();
      m_eip = fa; m_fetch = fa; m_err = 1'b0; m_inf = 1'b0;
    end else begin
      if (c) begin
        if (cl >= 3'd1 && cl <= 3'd4 && int'(cl) <= m_q.size()) begin
          for (int i = 0; i < int'(cl); i++) void'(m_q.pop_front());
          m_eip = m_eip + 32'(cl);
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_inf) m_q.push_back(mem_at(m_inf_addr));
      m_inf      = rq;
      m_inf_addr = m_fetch;
      if (rq) m_fetch = m_fetch + 32'd1;
    end
  endtask

  // One clock cycle: drive at the falling edge, check the settled outputs, advance the model.
  task automatic cycle(input logic r, input logic f, input logic [31:0] fa,
                       input logic c, input logic [2:0] cl);
    reset = r; flush = f; flush_addr = fa; consume = c; consume_len = cl;
    mem_rdata = pend ? mem_at(pend_addr) : 8'h00;
    #1;
    if (checking) check_outputs(r, f);
    pend = mem_req;
    pend_addr = mem_addr;
    model_step(r, f, fa, c, cl);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 3'd0);
  endtask

  task automatic eat(input logic [2:0] len);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, len);
  endtask

  task automatic idle_until(input int cnt, input logic inf, input string name);
    for (int k = 0; k < 30; k++) begin
      if (m_q.size() == cnt && m_inf == inf) return;
      idle();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for count=%0d inflight=%0d", name, cnt, inf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; flush_addr = '0; consume = 1'b0; consume_len = '0; mem_rdata = '0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
    checking = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ope", ope, 32'h0);

    // Fill from reset, no consume.
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (ope_valid === 1'b1 && lat < 0) begin
        lat = k;
        chk("fill_ope", ope, 32'h8b5dfc89);
      end
      idle();
    end
    chk("fill_latency", 32'(lat), 32'd5);
    chk("full_count", 32'(count), 32'd8);
    chk("full_mem_req", 32'(mem_req), 32'd0);

    // Variable-length consume across the wrap point.
    eat(3'd2);
    chk("eip_after_2", ope_eip, 32'd2);
    chk("win_after_2", ope, 32'hfc8945a0);
    repeat (3) idle();
    eat(3'd3);
    chk("eip_after_3", ope_eip, 32'd5);
    chk("win_after_3", ope, 32'ha0a3a2ad);
    repeat (3) idle();
    eat(3'd1);
    chk("eip_after_1", ope_eip, 32'd6);
    repeat (3) idle(); eat(3'd4);
    repeat (3) idle(); eat(3'd1);
    repeat (3) idle(); eat(3'd4);
    repeat (3) idle(); eat(3'd1);
    chk("eip_after_16", ope_eip, 32'd16);
    chk("err_after_16", 32'(consume_err), 32'd0);

    // Consume coinciding with a byte write.
    idle_until(8, 1'b0, "wait_full");
    eat(3'd1);
    idle_until(7, 1'b1, "wait_simul_1");
    eat(3'd1);
    chk("simul_count_7", 32'(count), 32'd7);
    idle_until(7, 1'b1, "wait_simul_4");
    eat(3'd4);
    chk("simul_count_4", 32'(count), 32'd4);

    // Flush while a request is in flight.
    idle_until(4, 1'b1, "wait_inflight");
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 3'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_eip", ope_eip, 32'h100);
    idle_until(1, 1'b1, "wait_first_after_flush");
    chk("flush_first_byte", 32'(ope[31:24]), 32'h85);

    // Illegal consume, sticky until flush.
    idle_until(2, 1'b1, "wait_count_2");
    eat(3'd4);
    chk("illegal_err", 32'(consume_err), 32'd1);
    chk("illegal_eip", ope_eip, 32'h100);
    repeat (4) idle();
    chk("err_sticky", 32'(consume_err), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0, 3'd0);
    chk("err_cleared", 32'(consume_err), 32'd0);
    idle_until(1, 1'b1, "wait_len0");
    eat(3'd0);
    chk("len0_err", 32'(consume_err), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0, 3'd0);
    chk("len0_cleared", 32'(consume_err), 32'd0);

    // Reset mid-operation.
    idle_until(5, 1'b1, "wait_count_5");
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 3'd0);
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_eip", ope_eip, RESET_ADDR);
    chk("midreset_mem_req", 32'(mem_req), 32'd0);
    idle_until(1, 1'b1, "wait_after_reset");
    chk("resume_byte", 32'(ope[31:24]), 32'h8b);
    chk("resume_eip", ope_eip, RESET_ADDR);
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
